mem_arbiter: RTL

Two-port arbiter that shares the single byte-wide synchronous memory (1 MiB, registered read data, one write strobe) between the core88 CPU (port A) and a secondary bus master such as a video or DMA engine (port B). It sits between the masters and the memory array, sequences each access through a fixed state machine and returns read data with a one-cycle ready pulse. The memory side matches the existing memory model exactly: address/data/write-enable sampled on the rising edge, read data valid the cycle after the address is presented.

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-wide synchronous memory between two bus masters.
// - Port A is the core88 CPU.
// - Port B is a secondary master, such as a video or DMA engine.
//
// Each access is sequenced through a fixed state machine:
//   IDLE -> ACC -> (RDATA) -> DONE
// Only one access is in flight at any time. The granted port receives a
// one-cycle ready pulse in DONE. For reads, the registered memory data is
// presented on that port's bus in the same cycle.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  When defined, port A wins every tie (fixed
//                          priority). When undefined, ties alternate
//                          round-robin.
//
// Ports:
//   clock                  System clock, rising edge.
//   reset                  Synchronous, active-high reset.
//   a_req / b_req          Request. Held with its qualifiers until ready.
//   a_address / b_address  Byte address (AW bits).
//   a_data / b_data        Write data.
//   a_wreq / b_wreq        1 = write, 0 = read.
//   a_bus / b_bus          Read data. Valid while ready is high;
//                          otherwise holds its last value.
//   a_ready / b_ready      One-cycle completion pulse.
//   m_address              Memory address (registered).
//   m_data                 Memory write data (registered).
//   m_wreq                 Memory write strobe (registered).
//   m_bus                  Memory read data. Registered inside the memory,
//                          valid one cycle after the address is presented.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 20
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_address,
    input  logic [7:0]    a_data,
    input  logic          a_wreq,
    output logic [7:0]    a_bus,
    output logic          a_ready,
    input  logic          b_req,
    input  logic [AW-1:0] b_address,
    input  logic [7:0]    b_data,
    input  logic          b_wreq,
    output logic [7:0]    b_bus,
    output logic          b_ready,
    output logic [AW-1:0] m_address,
    output logic [7:0]    m_data,
    output logic          m_wreq,
    input  logic [7:0]    m_bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_RDATA = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          grant_b_r;   // 1: port B owns the access in flight
    logic          grant_b_s;
    logic          wr_r;        // access in flight is a write
    logic          wr_s;
    logic          pick_b_s;    // arbitration outcome for this IDLE cycle
    logic [AW-1:0] m_address_s;
    logic [7:0]    m_data_s;
    logic          m_wreq_s;
    logic [7:0]    a_bus_s;
    logic [7:0]    b_bus_s;
    logic          a_ready_s;
    logic          b_ready_s;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: B is only chosen when A is not asking.
    always_comb begin
        pick_b_s = b_req & ~a_req;
    end
`else
    logic last_b_r;             // 1: the most recent grant went to port B
    logic last_b_s;

    // Round-robin: on a tie, the port that was not served last wins.
    always_comb begin
        pick_b_s = b_req & (~a_req | ~last_b_r);
    end
`endif

    // Next-state and next-output logic. Every output is registered below,
    // so no request or memory data reaches an output combinationally.
    always_comb begin
        state_s     = state_r;
        grant_b_s   = grant_b_r;
        wr_s        = wr_r;
        m_address_s = m_address;
        m_data_s    = m_data;
        m_wreq_s    = 1'b0;        // strobe lives only in the ACC cycle
        a_bus_s     = a_bus;
        b_bus_s     = b_bus;
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_b_s    = last_b_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    grant_b_s = pick_b_s;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_b_s  = pick_b_s;
`endif
                    state_s   = ST_ACC;
                    if (pick_b_s) begin
                        m_address_s = b_address;
                        m_data_s    = b_data;
                        m_wreq_s    = b_wreq;
                        wr_s        = b_wreq;
                    end else begin
                        m_address_s = a_address;
                        m_data_s    = a_data;
                        m_wreq_s    = a_wreq;
                        wr_s        = a_wreq;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                // The memory samples the access at the end of this cycle.
                if (wr_r) begin
                    state_s   = ST_DONE;
                    a_ready_s = ~grant_b_r;
                    b_ready_s = grant_b_r;
                end else begin
                    state_s = ST_RDATA;
                end
            end
            ST_RDATA: begin
                // Read data is valid now. It is captured into the granted
                // port's bus, and that port's ready rises with it.
                state_s = ST_DONE;
                if (grant_b_r) begin
                    b_bus_s   = m_bus;
                    b_ready_s = 1'b1;
                end else begin
                    a_bus_s   = m_bus;
                    a_ready_s = 1'b1;
                end
            end
            ST_DONE: begin
                // No grant decision is made here. A request still held
                // during its ready cycle is therefore not served twice.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            grant_b_r <= 1'b0;
            wr_r      <= 1'b0;
            m_address <= {AW{1'b0}};
            m_data    <= 8'h00;
            m_wreq    <= 1'b0;
            a_bus     <= 8'h00;
            b_bus     <= 8'h00;
            a_ready   <= 1'b0;
            b_ready   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_b_r  <= 1'b1;     // B counts as last, so A wins the first tie
`endif
        end else begin
            state_r   <= state_s;
            grant_b_r <= grant_b_s;
            wr_r      <= wr_s;
            m_address <= m_address_s;
            m_data    <= m_data_s;
            m_wreq    <= m_wreq_s;
            a_bus     <= a_bus_s;
            b_bus     <= b_bus_s;
            a_ready   <= a_ready_s;
            b_ready   <= b_ready_s;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_b_r  <= last_b_s;
`endif
        end
    end

endmodule
